// File: rtl/regread_arbiter_pkg.sv
// Shared select codes and arbiter FSM state type for the register-file read path.
// The rs1/rs2 source muxes decode the same SEL_* constants.
package proc_pkg;

    localparam logic [1:0] SEL_ADD    = 2'b00;
    localparam logic [1:0] SEL_MULT   = 2'b01;
    localparam logic [1:0] SEL_MULADD = 2'b10;
    localparam logic [1:0] SEL_IDLE   = 2'b11;

    // Bit positions of each requester in the req/mask/win vectors.
    localparam int IDX_ADD    = 0;
    localparam int IDX_MULT   = 1;
    localparam int IDX_MULADD = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_MA0  = 2'd2,
        ST_MA1  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/regread_arbiter_if.sv
// Request/grant bundle between the op controllers (master) and the read-port arbiter (slave).
interface regread_arbiter_if #(
    parameter int SEL_W = 2
);
    // Handshake: a controller holds req_x high until it sees gnt_x, then drops it the
    // following cycle; gnt_x is the accept, and a held req is never granted twice.
    logic             req_add;
    logic             req_mult;
    logic             req_muladd;
    logic             gnt_add;
    logic             gnt_mult;
    logic             gnt_muladd;
    logic             muladd_beat;
    logic [SEL_W-1:0] rs1_sel;
    logic [SEL_W-1:0] rs2_sel;
    logic             port_valid;

    modport master (
        output req_add, req_mult, req_muladd,
        input  gnt_add, gnt_mult, gnt_muladd, muladd_beat, rs1_sel, rs2_sel, port_valid
    );

    modport slave (
        input  req_add, req_mult, req_muladd,
        output gnt_add, gnt_mult, gnt_muladd, muladd_beat, rs1_sel, rs2_sel, port_valid
    );
endinterface

// File: rtl/regread_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: searches from the requester after 'last',
// ignoring masked requests, and returns a one-hot (or zero) winner.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [2:0] mask,
    input  logic [1:0] last,
    output logic [2:0] win
);
    logic [2:0] eff;

    assign eff = req & ~mask;

    always_comb begin
        logic [1:0] idx;
        win = '0;
        idx = '0;
        for (int i = 1; i <= 3; i++) begin
            idx = 2'((int'(last) + i) % 3);
            if (eff[idx] && (win == 3'b000)) begin
                win[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regread_arbiter.sv
// Round-robin arbiter for the shared rs1/rs2 read ports; MULADD gets a two-beat
// grant (rs1/rs2, then rs3 through the rs1 port). All outputs come from flops.
module regread_arbiter
    import proc_pkg::*;
#(
    parameter int SEL_W        = 2,
    parameter int MULADD_BEATS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    regread_arbiter_if.slave      bus,
    output arb_state_t            state_dbg
);
    arb_state_t       state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [2:0]       gnt_q, gnt_d;
    logic             beat_q, beat_d;
    logic [SEL_W-1:0] rs1_q, rs1_d;
    logic [SEL_W-1:0] rs2_q, rs2_d;
    logic             pv_q;
    logic [2:0]       req;
    logic [2:0]       win;

    assign req = {bus.req_muladd, bus.req_mult, bus.req_add};

    // The registered grant doubles as the mask: whoever owns the ports this cycle
    // is still holding req and must not win again at the next edge.
    rr_pick3 u_pick (
        .req  (req),
        .mask (gnt_q),
        .last (last_q),
        .win  (win)
    );

    always_comb begin
        state_d = ST_IDLE;
        last_d  = last_q;
        gnt_d   = 3'b000;
        beat_d  = 1'b0;
        rs1_d   = SEL_W'(SEL_IDLE);
        rs2_d   = SEL_W'(SEL_IDLE);
        if ((state_q == ST_MA0) && (MULADD_BEATS == 2)) begin
            state_d            = ST_MA1;
            gnt_d[IDX_MULADD]  = 1'b1;
            beat_d             = 1'b1;
            rs1_d              = SEL_W'(SEL_MULADD);
            rs2_d              = SEL_W'(SEL_IDLE);
        end else if (win[IDX_ADD]) begin
            state_d            = ST_GNT;
            last_d             = 2'(IDX_ADD);
            gnt_d[IDX_ADD]     = 1'b1;
            rs1_d              = SEL_W'(SEL_ADD);
            rs2_d              = SEL_W'(SEL_ADD);
        end else if (win[IDX_MULT]) begin
            state_d            = ST_GNT;
            last_d             = 2'(IDX_MULT);
            gnt_d[IDX_MULT]    = 1'b1;
            rs1_d              = SEL_W'(SEL_MULT);
            rs2_d              = SEL_W'(SEL_MULT);
        end else if (win[IDX_MULADD]) begin
            state_d            = ST_MA0;
            last_d             = 2'(IDX_MULADD);
            gnt_d[IDX_MULADD]  = 1'b1;
            rs1_d              = SEL_W'(SEL_MULADD);
            rs2_d              = SEL_W'(SEL_MULADD);
        end
    end

    // Reset leaves 'last' at MULADD so ADD is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 2'(IDX_MULADD);
            gnt_q   <= 3'b000;
            beat_q  <= 1'b0;
            rs1_q   <= SEL_W'(SEL_IDLE);
            rs2_q   <= SEL_W'(SEL_IDLE);
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            beat_q  <= beat_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            pv_q    <= |gnt_d;
        end
    end

    assign bus.gnt_add     = gnt_q[IDX_ADD];
    assign bus.gnt_mult    = gnt_q[IDX_MULT];
    assign bus.gnt_muladd  = gnt_q[IDX_MULADD];
    assign bus.muladd_beat = beat_q;
    assign bus.rs1_sel     = rs1_q;
    assign bus.rs2_sel     = rs2_q;
    assign bus.port_valid  = pv_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_regread_arbiter.sv
// Directed bench for regread_arbiter: stimulus pushes expected grants (cycle, owner,
// beat, selects) into a queue; a negedge monitor pops and compares each grant.
module tb_regread_arbiter;
    import proc_pkg::*;

    localparam int W = 23;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    arb_state_t state_dbg;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         c;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;
    logic [1:0]   mon_who;

    regread_arbiter_if #(.SEL_W(2)) bus ();

    regread_arbiter #(
        .SEL_W        (2),
        .MULADD_BEATS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] pack(int cy, int who, int beat, int s1, int s2);
        return {16'(cy), 2'(who), 1'(beat), 2'(s1), 2'(s2)};
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(int cy, int who, int beat, int s1, int s2);
        exp_q.push_back(pack(cy, who, beat, s1, s2));
    endtask

    task automatic drain(string name);
        tick(4);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_gnts"}, int'({bus.gnt_muladd, bus.gnt_mult, bus.gnt_add}), 0);
        check({tag, "_rs1"}, int'(bus.rs1_sel), 3);
        check({tag, "_rs2"}, int'(bus.rs2_sel), 3);
        check({tag, "_pv"}, int'(bus.port_valid), 0);
        check({tag, "_beat"}, int'(bus.muladd_beat), 0);
        check({tag, "_state"}, int'(state_dbg), int'(ST_IDLE));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        check("gnt_onehot0", int'($onehot0({bus.gnt_muladd, bus.gnt_mult, bus.gnt_add})), 1);
        check("pv_is_or_gnt", int'(bus.port_valid),
              int'(bus.gnt_add | bus.gnt_mult | bus.gnt_muladd));
        if (bus.port_valid) begin
            check("rs1_not_idle_when_valid", int'(bus.rs1_sel != 2'b11), 1);
            mon_who = bus.gnt_add ? 2'd0 : bus.gnt_mult ? 2'd1 : bus.gnt_muladd ? 2'd2 : 2'd3;
            mon_act = pack(cyc, int'(mon_who), int'(bus.muladd_beat),
                           int'(bus.rs1_sel), int'(bus.rs2_sel));
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_grant: got cyc=%0d who=%0d beat=%0d sel=%0d/%0d expected none",
                         cyc, mon_who, bus.muladd_beat, bus.rs1_sel, bus.rs2_sel);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    fails++;
                    $display("FAIL grant: got cyc=%0d who=%0d beat=%0d sel=%0d/%0d expected cyc=%0d who=%0d beat=%0d sel=%0d/%0d",
                             mon_act[22:7], mon_act[6:5], mon_act[4], mon_act[3:2], mon_act[1:0],
                             mon_exp[22:7], mon_exp[6:5], mon_exp[4], mon_exp[3:2], mon_exp[1:0]);
                end
            end
        end
    end

    initial begin
        bus.req_add    = 1'b1;
        bus.req_mult   = 1'b1;
        bus.req_muladd = 1'b1;
        #2 rst = 1'b1;

        // Reset with all requests high, then continuous requests: ADD, MULT, MULADD x2, ...
        tick(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        c = cyc;
        push(c + 1, 0, 0, 0, 0);
        push(c + 2, 1, 0, 1, 1);
        push(c + 3, 2, 0, 2, 2);
        push(c + 4, 2, 1, 2, 3);
        push(c + 5, 0, 0, 0, 0);
        push(c + 6, 1, 0, 1, 1);
        push(c + 7, 2, 0, 2, 2);
        push(c + 8, 2, 1, 2, 3);
        tick(8);
        bus.req_add    = 1'b0;
        bus.req_mult   = 1'b0;
        bus.req_muladd = 1'b0;
        drain("all_three_rr");

        // MULT alone; lingering req for one cycle must not re-grant
        c = cyc;
        bus.req_mult = 1'b1;
        push(c + 1, 1, 0, 1, 1);
        tick(2);
        bus.req_mult = 1'b0;
        drain("mult_alone");

        // MULADD alone, req held through both beats
        c = cyc;
        bus.req_muladd = 1'b1;
        push(c + 1, 2, 0, 2, 2);
        push(c + 2, 2, 1, 2, 3);
        tick(3);
        bus.req_muladd = 1'b0;
        drain("muladd_alone");

        // ADD rises during MA0 and waits until after MA1
        c = cyc;
        bus.req_muladd = 1'b1;
        push(c + 1, 2, 0, 2, 2);
        push(c + 2, 2, 1, 2, 3);
        push(c + 3, 0, 0, 0, 0);
        tick(1);
        bus.req_add = 1'b1;
        tick(1);
        bus.req_muladd = 1'b0;
        tick(2);
        bus.req_add = 1'b0;
        drain("add_during_ma0");

        // After an ADD grant, MULADD outranks ADD
        c = cyc;
        bus.req_add    = 1'b1;
        bus.req_muladd = 1'b1;
        push(c + 1, 2, 0, 2, 2);
        push(c + 2, 2, 1, 2, 3);
        push(c + 3, 0, 0, 0, 0);
        tick(2);
        bus.req_muladd = 1'b0;
        tick(2);
        bus.req_add = 1'b0;
        drain("rr_muladd_before_add");

        // After ADD, MULT wins over ADD; ADD follows with no bubble
        c = cyc;
        bus.req_add  = 1'b1;
        bus.req_mult = 1'b1;
        push(c + 1, 1, 0, 1, 1);
        push(c + 2, 0, 0, 0, 0);
        tick(2);
        bus.req_mult = 1'b0;
        tick(1);
        bus.req_add = 1'b0;
        drain("rr_mult_before_add");

        // Reset during MA1 aborts the beat; re-request restarts at MA0
        c = cyc;
        bus.req_muladd = 1'b1;
        push(c + 1, 2, 0, 2, 2);
        tick(2);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_in_ma1");
        tick(1);
        rst = 1'b0;
        c = cyc;
        push(c + 1, 2, 0, 2, 2);
        push(c + 2, 2, 1, 2, 3);
        tick(2);
        bus.req_muladd = 1'b0;
        drain("muladd_restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
